// File: rtl/ws2812_pkg.sv
// Shared types and timing math for the WS2812 LED pipeline.
// The timing helpers are also used by the LED-state stage, so keep them pure integer math.
package ws2812_pkg;

    typedef logic [23:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        LATCH = 2'd2
    } state_t;

    function automatic int ns_to_cyc(input int clk_mhz, input int ns);
        return (clk_mhz * ns) / 1000;
    endfunction

    function automatic int us_to_cyc(input int clk_mhz, input int us);
        return clk_mhz * us;
    endfunction

endpackage

// File: rtl/ws2812_bit_timer.sv
// Pulse-width shaping for one WS2812 bit: line level and end-of-bit strobe from the cycle count.
module ws2812_bit_timer #(
    parameter int T0H_CYC  = 9,
    parameter int T1H_CYC  = 18,
    parameter int TBIT_CYC = 33,
    parameter int CW       = $clog2(TBIT_CYC)
) (
    input  logic [CW-1:0] cyc_cnt,
    input  logic          bit_val,
    input  logic          en,
    output logic          data_lvl,
    output logic          bit_end
);

    localparam logic [CW-1:0] T0H_W  = CW'(T0H_CYC);
    localparam logic [CW-1:0] T1H_W  = CW'(T1H_CYC);
    localparam logic [CW-1:0] TEND_W = CW'(TBIT_CYC - 1);

    always_comb begin
        data_lvl = en & (cyc_cnt < (bit_val ? T1H_W : T0H_W));
        bit_end  = en & (cyc_cnt == TEND_W);
    end

endmodule

// File: rtl/ws2812_stream_tx.sv
// WS2812 stream serializer: one-word holding buffer, 24-bit shift register, NRZ bit timing
// and the end-of-frame latch period.
//
//   state | meaning
//   IDLE  | line low, waiting for a buffered word
//   SEND  | shifting SR out MSB-first, one bit per TBIT_CYC cycles
//   LATCH | line held low for RST_CYC cycles to latch the chain
module ws2812_stream_tx
    import ws2812_pkg::*;
#(
    parameter int CLK_MHZ  = 27,
    parameter int T0H_NS   = 350,
    parameter int T1H_NS   = 700,
    parameter int TBIT_NS  = 1250,
    parameter int RESET_US = 60
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] pix_data,
    input  logic        pix_valid,
    input  logic        pix_last,
    output logic        pix_ready,
    output logic        data,
    output logic        busy,
    output logic        frame_done,
    output logic        underrun
);

    localparam int T0H_CYC  = ns_to_cyc(CLK_MHZ, T0H_NS);
    localparam int T1H_CYC  = ns_to_cyc(CLK_MHZ, T1H_NS);
    localparam int TBIT_CYC = ns_to_cyc(CLK_MHZ, TBIT_NS);
    localparam int RST_CYC  = us_to_cyc(CLK_MHZ, RESET_US);
    localparam int CW       = $clog2(TBIT_CYC);
    localparam int LW       = $clog2(RST_CYC + 1);

    localparam logic [LW-1:0] LAT_END  = LW'(RST_CYC - 1);
    localparam logic [4:0]    LAST_BIT = 5'd23;

    state_t        state_q, state_d;
    pixel_t        sr_q, sr_d;
    logic          sr_last_q, sr_last_d;
    pixel_t        hb_q, hb_d;
    logic          hb_last_q, hb_last_d;
    logic          hb_full_q, hb_full_d;
    logic [4:0]    bit_cnt_q, bit_cnt_d;
    logic [CW-1:0] cyc_cnt_q, cyc_cnt_d;
    logic [LW-1:0] lat_cnt_q, lat_cnt_d;

    logic accept;
    logic drain;
    logic bit_end;
    logic data_lvl;

    assign accept    = pix_valid & ~hb_full_q;
    assign pix_ready = ~hb_full_q;
    assign busy      = (state_q != IDLE);
    assign data      = data_lvl;

    ws2812_bit_timer #(
        .T0H_CYC  (T0H_CYC),
        .T1H_CYC  (T1H_CYC),
        .TBIT_CYC (TBIT_CYC),
        .CW       (CW)
    ) u_bit_timer (
        .cyc_cnt  (cyc_cnt_q),
        .bit_val  (sr_q[23]),
        .en       (state_q == SEND),
        .data_lvl (data_lvl),
        .bit_end  (bit_end)
    );

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        sr_last_d  = sr_last_q;
        hb_d       = hb_q;
        hb_last_d  = hb_last_q;
        hb_full_d  = hb_full_q;
        bit_cnt_d  = bit_cnt_q;
        cyc_cnt_d  = cyc_cnt_q;
        lat_cnt_d  = lat_cnt_q;
        drain      = 1'b0;
        frame_done = 1'b0;
        underrun   = 1'b0;

        case (state_q)
            IDLE: begin
                if (hb_full_q) begin
                    sr_d      = hb_q;
                    sr_last_d = hb_last_q;
                    drain     = 1'b1;
                    bit_cnt_d = LAST_BIT;
                    cyc_cnt_d = '0;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (bit_end) begin
                    cyc_cnt_d = '0;
                    if (bit_cnt_q != 5'd0) begin
                        sr_d      = {sr_q[22:0], 1'b0};
                        bit_cnt_d = bit_cnt_q - 5'd1;
                    end else if (sr_last_q) begin
                        lat_cnt_d = '0;
                        state_d   = LATCH;
                    end else if (hb_full_q) begin
                        // back-to-back reload keeps the bit stream gap-free
                        sr_d      = hb_q;
                        sr_last_d = hb_last_q;
                        drain     = 1'b1;
                        bit_cnt_d = LAST_BIT;
                    end else begin
                        underrun = 1'b1;
                        state_d  = IDLE;
                    end
                end else begin
                    cyc_cnt_d = cyc_cnt_q + 1'b1;
                end
            end
            LATCH: begin
                if (lat_cnt_q == LAT_END) begin
                    frame_done = 1'b1;
                    lat_cnt_d  = '0;
                    state_d    = IDLE;
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // a refill in the same cycle as a drain leaves the buffer full with the new word
        if (accept) begin
            hb_d      = pix_data;
            hb_last_d = pix_last;
            hb_full_d = 1'b1;
        end else if (drain) begin
            hb_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            sr_last_q <= 1'b0;
            hb_q      <= '0;
            hb_last_q <= 1'b0;
            hb_full_q <= 1'b0;
            bit_cnt_q <= '0;
            cyc_cnt_q <= '0;
            lat_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            sr_last_q <= sr_last_d;
            hb_q      <= hb_d;
            hb_last_q <= hb_last_d;
            hb_full_q <= hb_full_d;
            bit_cnt_q <= bit_cnt_d;
            cyc_cnt_q <= cyc_cnt_d;
            lat_cnt_q <= lat_cnt_d;
        end
    end

endmodule

// File: tb/tb_ws2812_stream_tx.sv
// Directed bench for ws2812_stream_tx at 27 MHz: decodes the serial line by pulse width.
module tb_ws2812_stream_tx;

    localparam int T0H  = 9;
    localparam int T1H  = 18;
    localparam int TBIT = 33;
    localparam int RST  = 1620;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] pix_data = '0;
    logic        pix_valid = 1'b0;
    logic        pix_last = 1'b0;
    logic        pix_ready;
    logic        data;
    logic        busy;
    logic        frame_done;
    logic        underrun;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ws2812_stream_tx #(
        .CLK_MHZ  (27),
        .T0H_NS   (350),
        .T1H_NS   (700),
        .TBIT_NS  (1250),
        .RESET_US (60)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_last   (pix_last),
        .pix_ready  (pix_ready),
        .data       (data),
        .busy       (busy),
        .frame_done (frame_done),
        .underrun   (underrun)
    );

    // line monitor, sampled mid-cycle
    int cyc = 0;
    int hi_len = 0;
    bit prev_hi = 1'b0;
    bit bits_q[$];
    int rise_q[$];
    int bad_cnt = 0;
    int fd_cnt = 0;
    int fd_cyc = 0;
    bit busy_at_fd = 1'b0;
    int ur_cnt = 0;
    int ur_cyc = 0;

    always @(negedge clk) begin
        cyc++;
        if (data === 1'b1) begin
            if (!prev_hi) rise_q.push_back(cyc);
            hi_len++;
        end else if (hi_len > 0) begin
            if (hi_len == T1H) bits_q.push_back(1'b1);
            else if (hi_len == T0H) bits_q.push_back(1'b0);
            else bad_cnt++;
            hi_len = 0;
        end
        prev_hi = (data === 1'b1);
        if (frame_done === 1'b1) begin
            fd_cnt++;
            fd_cyc = cyc;
            busy_at_fd = busy;
        end
        if (underrun === 1'b1) begin
            ur_cnt++;
            ur_cyc = cyc;
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] word_at(input int idx);
        logic [23:0] w;
        w = '0;
        for (int i = 0; i < 24; i++) w = {w[22:0], bits_q[idx + i]};
        return w;
    endfunction

    // holds pix_valid high until the word is taken; leaves pix_valid high afterwards
    task automatic push(input logic [23:0] d, input logic last, output bit ok);
        int w;
        w = 0;
        pix_data  = d;
        pix_last  = last;
        pix_valid = 1'b1;
        while (!pix_ready && w < 3000) begin
            tick();
            w++;
        end
        ok = pix_ready;
        tick();
    endtask

    task automatic wait_fd(input int target, input int limit, output bit ok);
        int n;
        n = 0;
        while (fd_cnt < target && n < limit) begin
            tick();
            n++;
        end
        ok = (fd_cnt >= target);
    endtask

    task automatic wait_rises(input int target, input int limit, output bit ok);
        int n;
        n = 0;
        while (rise_q.size() < target && n < limit) begin
            tick();
            n++;
        end
        ok = (rise_q.size() >= target);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pix_valid = 1'b0;
        repeat (3) tick();
        n_checks++; if (data !== 1'b0) $display("FAIL reset_data got %b exp 0", data); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
        n_checks++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done got %b exp 0", frame_done); else n_pass++;
        n_checks++; if (underrun !== 1'b0) $display("FAIL reset_underrun got %b exp 0", underrun); else n_pass++;
        n_checks++; if (pix_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", pix_ready); else n_pass++;
        rst_n = 1'b1;
        repeat (2) tick();
        n_checks++; if (busy !== 1'b0) $display("FAIL post_reset_busy got %b exp 0", busy); else n_pass++;
    endtask

    task automatic test_single();
        int b0, r0, f0, u0, bad0, irr;
        bit ok;
        b0 = bits_q.size(); r0 = rise_q.size(); f0 = fd_cnt; u0 = ur_cnt; bad0 = bad_cnt;
        pix_data = 24'hFF0000; pix_last = 1'b1; pix_valid = 1'b1;
        n_checks++; if (pix_ready !== 1'b1) $display("FAIL single_ready_pre got %b exp 1", pix_ready); else n_pass++;
        tick();
        pix_valid = 1'b0;
        n_checks++; if (data !== 1'b0) $display("FAIL single_data_n1 got %b exp 0", data); else n_pass++;
        n_checks++; if (pix_ready !== 1'b0) $display("FAIL single_ready_n1 got %b exp 0", pix_ready); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL single_busy_n1 got %b exp 0", busy); else n_pass++;
        tick();
        n_checks++; if (data !== 1'b1) $display("FAIL single_data_n2 got %b exp 1", data); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL single_busy_n2 got %b exp 1", busy); else n_pass++;
        n_checks++; if (pix_ready !== 1'b1) $display("FAIL single_ready_n2 got %b exp 1", pix_ready); else n_pass++;
        wait_fd(f0 + 1, 4000, ok);
        n_checks++; if (!ok) $display("FAIL single_fd_timeout got %0d exp %0d", fd_cnt - f0, 1); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL single_busy_after_fd got %b exp 0", busy); else n_pass++;
        n_checks++; if (busy_at_fd !== 1'b1) $display("FAIL single_busy_at_fd got %b exp 1", busy_at_fd); else n_pass++;
        n_checks++; if (rise_q.size() - r0 != 24) $display("FAIL single_rises got %0d exp 24", rise_q.size() - r0); else n_pass++;
        n_checks++;
        if (fd_cyc != rise_q[r0] + 24 * TBIT + RST - 1)
            $display("FAIL single_fd_cycle got %0d exp %0d", fd_cyc - rise_q[r0], 24 * TBIT + RST - 1);
        else n_pass++;
        n_checks++;
        if (bits_q.size() - b0 != 24 || word_at(b0) !== 24'hFF0000)
            $display("FAIL single_word got %h (%0d bits) exp ff0000", word_at(b0), bits_q.size() - b0);
        else n_pass++;
        irr = 0;
        for (int i = r0 + 1; i < r0 + 24; i++) if (rise_q[i] - rise_q[i - 1] != TBIT) irr++;
        n_checks++; if (irr != 0) $display("FAIL single_bit_period got %0d irregular exp 0", irr); else n_pass++;
        n_checks++; if (bad_cnt != bad0) $display("FAIL single_pulse_width got %0d bad exp 0", bad_cnt - bad0); else n_pass++;
        n_checks++; if (ur_cnt != u0) $display("FAIL single_underrun got %0d exp 0", ur_cnt - u0); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [23:0] exp_w [3];
        int b0, r0, f0, u0, bad0, irr;
        bit ok1, ok2, ok3, ok;
        exp_w[0] = 24'hA5A5A5; exp_w[1] = 24'h000001; exp_w[2] = 24'h800000;
        b0 = bits_q.size(); r0 = rise_q.size(); f0 = fd_cnt; u0 = ur_cnt; bad0 = bad_cnt;
        push(exp_w[0], 1'b0, ok1);
        push(exp_w[1], 1'b0, ok2);
        push(exp_w[2], 1'b1, ok3);
        pix_valid = 1'b0;
        n_checks++; if (!(ok1 && ok2 && ok3)) $display("FAIL b2b_accept got %b%b%b exp 111", ok1, ok2, ok3); else n_pass++;
        wait_fd(f0 + 1, 6000, ok);
        n_checks++; if (!ok) $display("FAIL b2b_fd_timeout got %0d exp 1", fd_cnt - f0); else n_pass++;
        n_checks++; if (rise_q.size() - r0 != 72) $display("FAIL b2b_rises got %0d exp 72", rise_q.size() - r0); else n_pass++;
        irr = 0;
        for (int i = r0 + 1; i < r0 + 72; i++) if (rise_q[i] - rise_q[i - 1] != TBIT) irr++;
        n_checks++; if (irr != 0) $display("FAIL b2b_gap got %0d irregular periods exp 0", irr); else n_pass++;
        n_checks++;
        if (fd_cyc != rise_q[r0] + 72 * TBIT + RST - 1)
            $display("FAIL b2b_fd_cycle got %0d exp %0d", fd_cyc - rise_q[r0], 72 * TBIT + RST - 1);
        else n_pass++;
        n_checks++; if (bits_q.size() - b0 != 72) $display("FAIL b2b_bits got %0d exp 72", bits_q.size() - b0); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (word_at(b0 + 24 * k) !== exp_w[k]) $display("FAIL b2b_word%0d got %h exp %h", k, word_at(b0 + 24 * k), exp_w[k]);
            else n_pass++;
        end
        repeat (5) tick();
        n_checks++; if (fd_cnt - f0 != 1) $display("FAIL b2b_fd_count got %0d exp 1", fd_cnt - f0); else n_pass++;
        n_checks++; if (ur_cnt != u0) $display("FAIL b2b_underrun got %0d exp 0", ur_cnt - u0); else n_pass++;
        n_checks++; if (bad_cnt != bad0) $display("FAIL b2b_pulse_width got %0d bad exp 0", bad_cnt - bad0); else n_pass++;
    endtask

    task automatic test_underrun();
        int b0, r0, f0, u0, n, hi_seen;
        bit ok;
        b0 = bits_q.size(); r0 = rise_q.size(); f0 = fd_cnt; u0 = ur_cnt;
        push(24'h123456, 1'b0, ok);
        pix_valid = 1'b0;
        n = 0;
        while (ur_cnt == u0 && n < 2000) begin
            tick();
            n++;
        end
        n_checks++; if (ur_cnt - u0 != 1) $display("FAIL ur_pulse got %0d exp 1", ur_cnt - u0); else n_pass++;
        n_checks++;
        if (ur_cyc != rise_q[r0] + 24 * TBIT - 1) $display("FAIL ur_cycle got %0d exp %0d", ur_cyc - rise_q[r0], 24 * TBIT - 1);
        else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL ur_busy got %b exp 0", busy); else n_pass++;
        hi_seen = 0;
        repeat (100) begin
            tick();
            if (data !== 1'b0) hi_seen++;
        end
        n_checks++; if (hi_seen != 0) $display("FAIL ur_line_low got %0d high cycles exp 0", hi_seen); else n_pass++;
        n_checks++; if (ur_cnt - u0 != 1) $display("FAIL ur_single_pulse got %0d exp 1", ur_cnt - u0); else n_pass++;
        push(24'h00FF00, 1'b1, ok);
        pix_valid = 1'b0;
        wait_fd(f0 + 1, 4000, ok);
        n_checks++; if (!ok) $display("FAIL ur_resume_fd got %0d exp 1", fd_cnt - f0); else n_pass++;
        n_checks++; if (word_at(b0) !== 24'h123456) $display("FAIL ur_word0 got %h exp 123456", word_at(b0)); else n_pass++;
        n_checks++; if (word_at(b0 + 24) !== 24'h00FF00) $display("FAIL ur_word1 got %h exp 00ff00", word_at(b0 + 24)); else n_pass++;
        n_checks++; if (ur_cnt - u0 != 1) $display("FAIL ur_total got %0d exp 1", ur_cnt - u0); else n_pass++;
    endtask

    task automatic test_latch_fill();
        int b0, r0, f0, fdc;
        bit ok;
        b0 = bits_q.size(); r0 = rise_q.size(); f0 = fd_cnt;
        push(24'h0F0F0F, 1'b1, ok);
        pix_valid = 1'b0;
        wait_rises(r0 + 24, 2000, ok);
        repeat (100) tick();
        n_checks++; if (busy !== 1'b1 || fd_cnt != f0) $display("FAIL lf_in_latch got busy=%b fd=%0d exp busy=1 fd=0", busy, fd_cnt - f0); else n_pass++;
        pix_data = 24'h010203; pix_last = 1'b1; pix_valid = 1'b1;
        n_checks++; if (pix_ready !== 1'b1) $display("FAIL lf_ready_pre got %b exp 1", pix_ready); else n_pass++;
        tick();
        pix_valid = 1'b0;
        n_checks++; if (pix_ready !== 1'b0) $display("FAIL lf_ready_full got %b exp 0", pix_ready); else n_pass++;
        repeat (10) tick();
        n_checks++; if (pix_ready !== 1'b0 || busy !== 1'b1) $display("FAIL lf_held got ready=%b busy=%b exp 0 1", pix_ready, busy); else n_pass++;
        wait_fd(f0 + 1, 3000, ok);
        fdc = fd_cyc;
        n_checks++; if (!ok) $display("FAIL lf_fd1 got %0d exp 1", fd_cnt - f0); else n_pass++;
        n_checks++; if (rise_q.size() - r0 != 24) $display("FAIL lf_no_early_start got %0d rises exp 24", rise_q.size() - r0); else n_pass++;
        wait_fd(f0 + 2, 4000, ok);
        n_checks++; if (!ok) $display("FAIL lf_fd2 got %0d exp 2", fd_cnt - f0); else n_pass++;
        n_checks++; if (rise_q[r0 + 24] != fdc + 2) $display("FAIL lf_restart got %0d exp 2", rise_q[r0 + 24] - fdc); else n_pass++;
        n_checks++; if (word_at(b0) !== 24'h0F0F0F) $display("FAIL lf_word0 got %h exp 0f0f0f", word_at(b0)); else n_pass++;
        n_checks++; if (word_at(b0 + 24) !== 24'h010203) $display("FAIL lf_word1 got %h exp 010203", word_at(b0 + 24)); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int r0, r1, b1, f0, u0;
        bit ok;
        r0 = rise_q.size(); f0 = fd_cnt; u0 = ur_cnt;
        push(24'hC3C3C3, 1'b1, ok);
        pix_valid = 1'b0;
        wait_rises(r0 + 10, 2000, ok);
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++; if (data !== 1'b0) $display("FAIL rm_data got %b exp 0", data); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rm_busy got %b exp 0", busy); else n_pass++;
        n_checks++; if (pix_ready !== 1'b1) $display("FAIL rm_ready got %b exp 1", pix_ready); else n_pass++;
        r1 = rise_q.size();
        repeat (200) tick();
        n_checks++; if (fd_cnt != f0) $display("FAIL rm_no_fd got %0d exp 0", fd_cnt - f0); else n_pass++;
        n_checks++; if (rise_q.size() != r1 || ur_cnt != u0) $display("FAIL rm_quiet got %0d rises %0d underruns exp 0 0", rise_q.size() - r1, ur_cnt - u0); else n_pass++;
        b1 = bits_q.size();
        push(24'h5A5A5A, 1'b1, ok);
        pix_valid = 1'b0;
        wait_fd(f0 + 1, 4000, ok);
        n_checks++; if (!ok) $display("FAIL rm_new_fd got %0d exp 1", fd_cnt - f0); else n_pass++;
        n_checks++;
        if (bits_q.size() - b1 != 24 || word_at(b1) !== 24'h5A5A5A)
            $display("FAIL rm_new_word got %h (%0d bits) exp 5a5a5a", word_at(b1), bits_q.size() - b1);
        else n_pass++;
    endtask

    task automatic test_random_stalls();
        logic [23:0] exp_q[$];
        logic [23:0] w;
        logic l;
        int b0, f0, u0, bad0, wt, errs;
        bit acc, ok;
        b0 = bits_q.size(); f0 = fd_cnt; u0 = ur_cnt; bad0 = bad_cnt;
        errs = 0;
        for (int k = 0; k < 30; k++) begin
            w = 24'($urandom);
            l = (k % 10 == 9);
            acc = 1'b0;
            wt = 0;
            while (!acc && wt < 3000) begin
                if (pix_ready) begin
                    pix_data = w; pix_last = l; pix_valid = 1'b1;
                    tick();
                    acc = 1'b1;
                end else begin
                    if ($urandom_range(1, 0) == 1) begin
                        pix_data = w; pix_last = l; pix_valid = 1'b1;
                    end else begin
                        pix_valid = 1'b0; pix_data = 24'($urandom); pix_last = 1'($urandom_range(1, 0));
                    end
                    tick();
                    wt++;
                end
            end
            if (acc) exp_q.push_back(w);
            pix_valid = 1'b0;
            pix_data = 24'($urandom);
            repeat ($urandom_range(3, 0)) tick();
        end
        pix_valid = 1'b0;
        n_checks++; if (exp_q.size() != 30) $display("FAIL rnd_accepts got %0d exp 30", exp_q.size()); else n_pass++;
        wait_fd(f0 + 3, 40000, ok);
        n_checks++; if (!ok) $display("FAIL rnd_fd_timeout got %0d exp 3", fd_cnt - f0); else n_pass++;
        n_checks++; if (bits_q.size() - b0 != 24 * exp_q.size()) $display("FAIL rnd_bits got %0d exp %0d", bits_q.size() - b0, 24 * exp_q.size()); else n_pass++;
        for (int k = 0; k < exp_q.size(); k++) begin
            n_checks++;
            if (word_at(b0 + 24 * k) !== exp_q[k]) begin
                $display("FAIL rnd_word%0d got %h exp %h", k, word_at(b0 + 24 * k), exp_q[k]);
                errs++;
            end else n_pass++;
        end
        repeat (5) tick();
        n_checks++; if (fd_cnt - f0 != 3) $display("FAIL rnd_fd_count got %0d exp 3", fd_cnt - f0); else n_pass++;
        n_checks++; if (ur_cnt != u0) $display("FAIL rnd_underrun got %0d exp 0", ur_cnt - u0); else n_pass++;
        n_checks++; if (bad_cnt != bad0) $display("FAIL rnd_pulse_width got %0d bad exp 0", bad_cnt - bad0); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_underrun();
        test_latch_fill();
        test_reset_mid();
        test_random_stalls();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
